// File: rtl/dither_dac_sequencer.sv
// Sample-rate sequencer for the dithered DAC: sample FIFO, period counter,
// LFSR save/restore/advance control and a click-free ramp to midscale on disable.
module dither_dac_sequencer #(
  parameter int SIGNALWIDTH = 16,
  parameter int DEPTH       = 4,
  parameter int DIVIDER     = 256,
  parameter int RAMPSTEP    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_replay,
  input  logic                   i_clear_flags,
  input  logic                   i_in_valid,
  input  logic [SIGNALWIDTH-1:0] i_in_data,
  output logic                   o_in_ready,
  output logic [SIGNALWIDTH-1:0] o_dac_d,
  output logic                   o_sample_tick,
  output logic                   o_lfsr_e,
  output logic                   o_lfsr_save,
  output logic                   o_lfsr_restore,
  output logic                   o_underrun,
  output logic                   o_busy
);

  localparam int W  = SIGNALWIDTH;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [W-1:0] MID = W'(1) << (W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RAMP} state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_underrun;
  logic [W-1:0]  r_dac;
  logic [CW-1:0] r_div;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_tick;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_in_ready;
  logic          w_restore;
  logic [W:0]    w_dac_ext;
  logic [W:0]    w_mid_ext;
  logic [W:0]    w_step;
  logic [W:0]    w_up;
  logic [W:0]    w_dn;
  logic [W:0]    w_above;
  logic [W-1:0]  w_ramp_next;

  assign w_tick     = (r_state != S_IDLE) && (r_div == CW'(DIVIDER - 1));
  // in_ready looks only at the registered count, so a same-cycle pop never frees a slot
  assign w_in_ready = (r_count < (AW+1)'(DEPTH)) && (r_state != S_RAMP);
  assign w_push     = i_in_valid && w_in_ready;
  assign w_pop      = (r_state == S_RUN) && w_tick && (r_count != '0);
  assign w_flush    = (r_state == S_RUN) && !i_enable;
  assign w_restore  = w_tick && i_replay;

  // Ramp arithmetic carries one extra bit so the step can neither wrap nor overshoot MID
  assign w_dac_ext  = {1'b0, r_dac};
  assign w_mid_ext  = {1'b0, MID};
  assign w_step     = (W+1)'(RAMPSTEP);
  assign w_up       = w_dac_ext + w_step;
  assign w_dn       = w_dac_ext - w_step;
  assign w_above    = w_dac_ext - w_mid_ext;
  assign w_ramp_next = (r_dac < MID) ? ((w_up >= w_mid_ext) ? MID : w_up[W-1:0])
                                     : ((w_above <= w_step) ? MID : w_dn[W-1:0]);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_in_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
      r_dac      <= MID;
      r_div      <= '0;
    end else begin
      if ((r_state == S_RUN) && w_tick && (r_count == '0))
        r_underrun <= 1'b1;
      else if (i_clear_flags)
        r_underrun <= 1'b0;

      if (r_state == S_IDLE || w_tick)
        r_div <= '0;
      else
        r_div <= r_div + CW'(1);

      case (r_state)
        S_IDLE: begin
          if (i_enable) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_pop) r_dac <= r_mem[r_rd_ptr];
          if (!i_enable) r_state <= S_RAMP;
        end
        S_RAMP: begin
          if (w_tick) begin
            if (r_dac == MID) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_dac <= w_ramp_next;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready     = w_in_ready;
  assign o_dac_d        = r_dac;
  assign o_sample_tick  = w_tick;
  assign o_lfsr_restore = w_restore;
  assign o_lfsr_e       = (r_state != S_IDLE) && !w_restore;
  assign o_lfsr_save    = (r_state == S_IDLE) && i_enable;
  assign o_underrun     = r_underrun;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_dither_dac_sequencer.sv
// Directed bench for dither_dac_sequencer with divider=4, depth=4, rampstep=0x1000.
module tb_dither_dac_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        replay;
  logic        clear_flags;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] dac_d;
  logic        sample_tick;
  logic        lfsr_e;
  logic        lfsr_save;
  logic        lfsr_restore;
  logic        underrun;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dither_dac_sequencer #(
    .SIGNALWIDTH(16), .DEPTH(4), .DIVIDER(4), .RAMPSTEP(16'h1000)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_replay(replay),
    .i_clear_flags(clear_flags), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .o_dac_d(dac_d), .o_sample_tick(sample_tick),
    .o_lfsr_e(lfsr_e), .o_lfsr_save(lfsr_save), .o_lfsr_restore(lfsr_restore),
    .o_underrun(underrun), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; checks sample 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    enable = 0; replay = 0; clear_flags = 0; in_valid = 0; in_data = '0;
    do_reset();
    #1;
    checks++; if (dac_d !== 16'h8000) begin errors++; $display("FAIL reset_dac got %h exp 8000", dac_d); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (lfsr_e !== 1'b0) begin errors++; $display("FAIL reset_lfsr_e got %b exp 0", lfsr_e); end
    checks++; if (underrun !== 1'b0 || sample_tick !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", underrun, sample_tick); end
    in_valid = 1; in_data = 16'h1234;
    step();
    in_data = 16'h5678;
    step();
    in_valid = 0;
    #1;
    checks++; if (dut.r_count !== 3'd2) begin errors++; $display("FAIL prefill_count got %0d exp 2", dut.r_count); end
    checks++; if (busy !== 1'b0 || dac_d !== 16'h8000) begin errors++; $display("FAIL prefill_idle got busy %b dac %h exp 0 8000", busy, dac_d); end
  endtask

  task automatic test_streaming();
    int saves;
    int ticks;
    logic [15:0] exp_dac [3];
    exp_dac[0] = 16'h1234; exp_dac[1] = 16'h5678; exp_dac[2] = 16'h5678;
    saves = 0; ticks = 0;
    enable = 1;
    #1;
    checks++; if (lfsr_save !== 1'b1) begin errors++; $display("FAIL save_pulse got %b exp 1", lfsr_save); end
    step();
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 4; k++) begin
        #1;
        if (lfsr_save === 1'b1) saves++;
        if (sample_tick === 1'b1) ticks++;
        checks++; if (sample_tick !== (k == 3)) begin errors++; $display("FAIL stream_tick t%0d k%0d got %b exp %b", t, k, sample_tick, (k == 3)); end
        step();
      end
      #1;
      checks++; if (dac_d !== exp_dac[t]) begin errors++; $display("FAIL stream_dac t%0d got %h exp %h", t, dac_d, exp_dac[t]); end
      checks++; if (underrun !== (t == 2)) begin errors++; $display("FAIL stream_underrun t%0d got %b exp %b", t, underrun, (t == 2)); end
    end
    checks++; if (saves !== 0 || ticks !== 3) begin errors++; $display("FAIL stream_counts saves %0d ticks %0d exp 0 3", saves, ticks); end
  endtask

  // Runs right after the third streaming tick: divider phase is 0, FIFO empty, underrun set.
  task automatic test_flag_priority();
    clear_flags = 1;
    step();
    clear_flags = 0;
    #1;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL flag_clear got %b exp 0", underrun); end
    step();
    step();
    clear_flags = 1;
    #1;
    checks++; if (sample_tick !== 1'b1) begin errors++; $display("FAIL flag_tick_align got %b exp 1", sample_tick); end
    step();
    clear_flags = 0;
    #1;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL flag_priority got %b exp 1", underrun); end
  endtask

  task automatic test_full();
    enable = 0;
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 16'hA000 + 16'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready i%0d got %b exp 1", i, in_ready); end
      step();
    end
    in_data = 16'hA004;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", in_ready); end
    checks++; if (dut.r_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", dut.r_count); end
    enable = 1;
    step();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_tick_reject k%0d got %b exp 0", k, in_ready); end
      step();
    end
    #1;
    checks++; if (in_ready !== 1'b1 || dac_d !== 16'hA000) begin errors++; $display("FAIL full_after_pop got ready %b dac %h exp 1 a000", in_ready, dac_d); end
    step();
    in_valid = 0;
    #1;
    checks++; if (dut.r_count !== 3'd4) begin errors++; $display("FAIL full_accept got %0d exp 4", dut.r_count); end
  endtask

  // Divider phase is 1 on entry; FIFO holds A001..A004.
  task automatic test_replay();
    int ph;
    replay = 1;
    for (int k = 0; k < 8; k++) begin
      ph = (1 + k) % 4;
      #1;
      checks++; if (lfsr_restore !== (ph == 3)) begin errors++; $display("FAIL replay_restore k%0d got %b exp %b", k, lfsr_restore, (ph == 3)); end
      checks++; if (lfsr_e !== (ph != 3)) begin errors++; $display("FAIL replay_lfsr_e k%0d got %b exp %b", k, lfsr_e, (ph != 3)); end
      step();
    end
    replay = 0;
    #1;
    checks++; if (dac_d !== 16'hA002) begin errors++; $display("FAIL replay_dac got %h exp a002", dac_d); end
  endtask

  task automatic test_ramp();
    int ph;
    int ticks;
    logic [15:0] tbl [3];
    tbl[0] = 16'h6800; tbl[1] = 16'h7800; tbl[2] = 16'h8000;
    enable = 0;
    do_reset();
    in_valid = 1; in_data = 16'h5800;
    step();
    in_valid = 0;
    enable = 1;
    step();
    for (int k = 0; k < 4; k++) step();
    in_valid = 1; in_data = 16'h1111;
    step();
    in_valid = 0;
    enable = 0;
    #1;
    checks++; if (dac_d !== 16'h5800 || dut.r_count !== 3'd1) begin errors++; $display("FAIL ramp_setup got dac %h count %0d exp 5800 1", dac_d, dut.r_count); end
    step();
    in_valid = 1; in_data = 16'hBEEF;
    #1;
    checks++; if (dut.r_count !== 3'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL ramp_flush got count %0d ready %b exp 0 0", dut.r_count, in_ready); end
    ph = 2; ticks = 0;
    for (int c = 0; c < 20; c++) begin
      enable = (c == 3);
      #1;
      checks++; if (sample_tick !== (ph == 3)) begin errors++; $display("FAIL ramp_tick c%0d got %b exp %b", c, sample_tick, (ph == 3)); end
      checks++; if (lfsr_e !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL ramp_ctrl c%0d got e %b ready %b exp 1 0", c, lfsr_e, in_ready); end
      step();
      if (ph == 3) begin
        ticks++;
        #1;
        if (ticks <= 3) begin
          checks++; if (dac_d !== tbl[ticks-1] || busy !== 1'b1) begin errors++; $display("FAIL ramp_step%0d got dac %h busy %b exp %h 1", ticks, dac_d, busy, tbl[ticks-1]); end
        end else begin
          in_valid = 0;
          checks++; if (busy !== 1'b0 || dac_d !== 16'h8000) begin errors++; $display("FAIL ramp_idle got busy %b dac %h exp 0 8000", busy, dac_d); end
          break;
        end
      end
      ph = (ph + 1) % 4;
    end
    in_valid = 0;
    checks++; if (ticks !== 4) begin errors++; $display("FAIL ramp_timeout ticks %0d exp 4", ticks); end
    checks++; if (dut.r_count !== 3'd0) begin errors++; $display("FAIL ramp_fifo_empty got %0d exp 0", dut.r_count); end
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    in_valid = 1; in_data = 16'h1000;
    step();
    in_valid = 0;
    enable = 1;
    step();
    for (int k = 0; k < 4; k++) step();
    enable = 0;
    step();
    for (int k = 0; k < 4; k++) step();
    #1;
    checks++; if (dac_d !== 16'h2000 || busy !== 1'b1) begin errors++; $display("FAIL midramp_setup got dac %h busy %b exp 2000 1", dac_d, busy); end
    step();
    reset = 1;
    step();
    reset = 0;
    #1;
    checks++; if (dac_d !== 16'h8000 || busy !== 1'b0) begin errors++; $display("FAIL midramp_reset got dac %h busy %b exp 8000 0", dac_d, busy); end
    checks++; if (dut.r_count !== 3'd0 || in_ready !== 1'b1 || lfsr_e !== 1'b0) begin errors++; $display("FAIL midramp_fifo got count %0d ready %b e %b exp 0 1 0", dut.r_count, in_ready, lfsr_e); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_flag_priority();
    test_full();
    test_replay();
    test_ramp();
    test_reset_mid_ramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
